// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHK,
    DONE,
    ERR
  } loader_state_t;

  localparam int unsigned LEN_BYTES = 4;

endpackage

// File: rtl/instr_loader_if.sv
// Stream input and instruction-memory byte write port of the program loader.
// slave: loader side; master: stream source / memory side.
interface instr_loader_if #(
  parameter int unsigned ADDRESS_WIDTH = 32
);

  logic                     in_valid;
  logic [7:0]               in_data;
  logic                     in_ready;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [7:0]               mem_wdata;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/instr_loader.sv
// Length-prefixed byte-stream loader writing into the instruction memory.
// Define INSTR_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module instr_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned SIZE          = 14,
  parameter int unsigned BASE_ADDR     = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  instr_loader_if.slave  bus,
  output logic           cpu_hold,
  output logic           busy,
  output logic           done,
  output logic           err
);

  // Largest payload that fits between BASE_ADDR and the end of memory.
  localparam logic [32:0] LEN_LIMIT = 33'((64'd1 << SIZE) - 64'(BASE_ADDR));

  loader_state_t            state_q, state_d;
  logic [31:0]              len_q, len_d;
  logic [1:0]               len_cnt_q, len_cnt_d;
  logic [31:0]              byte_cnt_q, byte_cnt_d;
  logic                     mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]               mem_wdata_q, mem_wdata_d;
  logic                     cpu_hold_q, cpu_hold_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]               xor_q, xor_d;
`endif

  logic        in_ready;
  logic        accept;
  logic [31:0] len_next;
  logic [31:0] byte_cnt_inc;
  logic [31:0] addr_full;

  assign in_ready     = (state_q == LEN) || (state_q == DATA);
  assign accept       = bus.in_valid && in_ready;
  assign len_next     = {bus.in_data, len_q[31:8]};
  assign byte_cnt_inc = byte_cnt_q + 32'd1;
  assign addr_full    = BASE_ADDR + byte_cnt_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    len_cnt_d   = len_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    xor_d       = xor_q;
`endif

    unique case (state_q)
      IDLE, DONE, ERR: begin
        // The final write was issued in the first DONE cycle, so release here.
        if (state_q == DONE) begin
          cpu_hold_d = 1'b0;
        end
        if (start) begin
          state_d    = LEN;
          len_d      = '0;
          len_cnt_d  = '0;
          byte_cnt_d = '0;
          cpu_hold_d = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
          xor_d      = '0;
`endif
        end
      end

      LEN: begin
        if (accept) begin
          len_d     = len_next;
          len_cnt_d = len_cnt_q + 2'd1;
          if (len_cnt_q == 2'(LEN_BYTES - 1)) begin
            if (len_next == 32'd0) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
              state_d = CHK;
`else
              state_d = DONE;
`endif
            end else if ({1'b0, len_next} > LEN_LIMIT) begin
              state_d = ERR;
            end else begin
              state_d    = DATA;
              byte_cnt_d = '0;
            end
          end
        end
      end

      DATA: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ADDRESS_WIDTH'(addr_full);
          mem_wdata_d = bus.in_data;
          byte_cnt_d  = byte_cnt_inc;
`ifdef INSTR_LOADER_CHECKSUM_EN
          xor_d       = xor_q ^ bus.in_data;
          if (byte_cnt_inc == len_q) begin
            state_d = CHK;
          end
`else
          if (byte_cnt_inc == len_q) begin
            state_d = DONE;
          end
`endif
        end
      end

`ifdef INSTR_LOADER_CHECKSUM_EN
      CHK: begin
        if (bus.in_valid) begin
          state_d = (bus.in_data == xor_q) ? DONE : ERR;
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      len_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      len_cnt_q   <= len_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_q       <= xor_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_hold      = cpu_hold_q;
  assign busy          = (state_q == LEN) || (state_q == DATA) || (state_q == CHK);
  assign done          = (state_q == DONE);
  assign err           = (state_q == ERR);

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected writes are queued by the stimulus
// and checked by an independent monitor on every mem_we pulse.
module tb_instr_loader;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpu_hold, busy, done, err;

  always #5 clk = ~clk;

  instr_loader_if #(.ADDRESS_WIDTH(32)) bus ();

  instr_loader #(
    .ADDRESS_WIDTH(32),
    .SIZE         (14),
    .BASE_ADDR    (0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .cpu_hold(cpu_hold),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  exp_addr;
  int  total;
  int  bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every write pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
          bad++;
          $display("FAIL write: got addr=%0h data=%0h expected addr=%0h data=%0h",
                   bus.mem_addr, bus.mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      chk("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    step();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic payload(input logic [7:0] b);
    exp_q.push_back('{addr: 32'(exp_addr), data: b});
    exp_addr++;
    send(b);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_addr = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] img1[8] = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    logic [7:0] img2[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0] tog[$];
    int idx;
    total = 0;
    bad   = 0;
    exp_addr = 0;
    rst   = 1'b1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    step();
    step();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
    chk("rst_status", {28'd0, cpu_hold, busy, done, err}, 32'd0);
    rst = 1'b0;
    step();

    // Bytes offered while idle must be dropped.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    step();
    step();
    bus.in_valid = 1'b0;
    chk("idle_no_ready", {31'd0, bus.in_ready}, 32'd0);

    // Basic 8-byte image.
    do_start();
    chk("start_status", {28'd0, cpu_hold, busy, done, err}, 32'b1100);
    send(8'h08); send(8'h00); send(8'h00); send(8'h00);
    for (int i = 0; i < 8; i++) payload(img1[i]);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send(8'h90);
`endif
    chk("img1_done_first", {28'd0, cpu_hold, busy, done, err}, 32'b1010);
    step();
    chk("img1_done_released", {28'd0, cpu_hold, busy, done, err}, 32'b0010);

    // Zero length.
    do_start();
    chk("restart_clears_done", {31'd0, done}, 32'd0);
    send(8'h00); send(8'h00); send(8'h00); send(8'h00);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    chk("len0_done", {31'd0, done}, 32'd1);
    step();
    chk("len0_released", {28'd0, cpu_hold, busy, done, err}, 32'b0010);

    // Oversize length 0x4001.
    do_start();
    send(8'h01); send(8'h40); send(8'h00); send(8'h00);
    chk("oversize_err", {28'd0, cpu_hold, busy, done, err}, 32'b1001);
    step();
    step();
    chk("oversize_hold", {28'd0, cpu_hold, busy, done, err}, 32'b1001);
    do_start();
    chk("err_cleared", {28'd0, cpu_hold, busy, done, err}, 32'b1100);

    // Reset after three payload bytes of an 8-byte image.
    send(8'h08); send(8'h00); send(8'h00); send(8'h00);
    payload(8'h11); payload(8'h22); payload(8'h33);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midreset_status", {28'd0, cpu_hold, busy, done, err}, 32'b0000);
    chk("midreset_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h44;
    step();
    bus.in_valid = 1'b0;

    // Fresh 4-byte image after reset.
    do_start();
    send(8'h04); send(8'h00); send(8'h00); send(8'h00);
    for (int i = 0; i < 4; i++) payload(img2[i]);
`ifdef INSTR_LOADER_CHECKSUM_EN
    send(8'h22);
`endif
    step();
    chk("img2_done", {28'd0, cpu_hold, busy, done, err}, 32'b0010);

    // in_valid toggling every cycle, start pulsed mid-payload.
    tog = '{8'h03, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3};
`ifdef INSTR_LOADER_CHECKSUM_EN
    tog.push_back(8'hA0);
`endif
    do_start();
    idx = 0;
    for (int c = 0; c < 2 * tog.size(); c++) begin
      start = (idx == 5 && c[0]);
      if (!c[0]) begin
        if (idx >= 4 && idx < 7) begin
          exp_q.push_back('{addr: 32'(idx - 4), data: tog[idx]});
        end
        bus.in_valid = 1'b1;
        bus.in_data  = tog[idx];
        idx++;
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hEE;
      end
      step();
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    step();
    chk("toggle_done", {28'd0, cpu_hold, busy, done, err}, 32'b0010);

`ifdef INSTR_LOADER_CHECKSUM_EN
    do_start();
    send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    payload(8'hAA); payload(8'h55);
    send(8'hFF);
    chk("csum_good", {31'd0, done}, 32'd1);
    do_start();
    send(8'h02); send(8'h00); send(8'h00); send(8'h00);
    payload(8'hAA); payload(8'h55);
    send(8'h00);
    chk("csum_bad", {28'd0, cpu_hold, busy, done, err}, 32'b1001);
`endif

    step();
    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
